// File: rtl/gtp_wr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// gtp_wr_scheduler_pkg
// Shared definitions for the GTP -> MCB write scheduler and the port-0
// controller: scheduler state encoding, MCB command opcodes, and the
// channel count.
// ---------------------------------------------------------------------------
package gtp_wr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CMD  = 2'd2
    } state_t;

    // MCB command opcodes (write / read with auto-precharge)
    localparam logic [2:0] MCB_INSTR_WR_AP = 3'b010;
    localparam logic [2:0] MCB_INSTR_RD_AP = 3'b011;

    localparam int NCH = 4;

    // One-hot decode of a 2-bit channel index
    function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
        logic [NCH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gtp_wr_scheduler_if.sv
// ---------------------------------------------------------------------------
// gtp_wr_scheduler_if
// MCB port-2 (write-only) bus: write-data FIFO push side plus command FIFO.
//   master : the scheduler (drives strobes, data, command fields)
//   slave  : the memory controller (drives the two FIFO-full flags)
// ---------------------------------------------------------------------------
interface gtp_wr_scheduler_if;
    logic        mcb_wr_en;
    logic [31:0] mcb_wr_data;
    logic        mcb_wr_full;
    logic        mcb_cmd_en;
    logic [2:0]  mcb_cmd_instr;
    logic [5:0]  mcb_cmd_bl;
    logic [28:0] mcb_cmd_byte_addr;
    logic        mcb_cmd_full;

    modport master (
        output mcb_wr_en, mcb_wr_data, mcb_cmd_en, mcb_cmd_instr,
               mcb_cmd_bl, mcb_cmd_byte_addr,
        input  mcb_wr_full, mcb_cmd_full
    );

    modport slave (
        input  mcb_wr_en, mcb_wr_data, mcb_cmd_en, mcb_cmd_instr,
               mcb_cmd_bl, mcb_cmd_byte_addr,
        output mcb_wr_full, mcb_cmd_full
    );
endinterface

// File: rtl/gtp_wr_scheduler_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// gtp_wr_scheduler_rr_arbiter4  (rr_arbiter4)
// Purely combinational 4-way round-robin arbiter. Also used for read-side
// arbitration.
//   i_req   : request vector
//   i_last  : index of the most recently served requester
//   o_grant : first requester found searching from i_last+1 (mod 4)
//   o_valid : at least one request present
// ---------------------------------------------------------------------------
module gtp_wr_scheduler_rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    logic [1:0] w_idx;

    // Scan from the farthest candidate down to the nearest so the nearest
    // requester after i_last is the one left standing.
    always_comb begin
        o_grant = 2'd0;
        o_valid = 1'b0;
        w_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = i_last + 2'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gtp_wr_scheduler.sv
// ---------------------------------------------------------------------------
// gtp_wr_scheduler
// Shares MCB write port 2 between the four GTP receive channel buffers.
// A channel holding a full block is granted round-robin, BLOCK_LEN words are
// streamed into the MCB write FIFO, then one write-with-autoprecharge command
// is issued at the current ring-buffer address. Single clock domain (wb_clk).
//
// Ports:
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   enable         : allow new grants (current block always completes)
//   ch_req[3:0]    : channel i holds >= BLOCK_LEN words
//   ch_dat[127:0]  : FWFT head word of channel i at [32i+31:32i]
//   ch_rd[3:0]     : one-hot pop strobe to the granted channel
//   mcb            : MCB port-2 write/command bus (master side)
//   rd_ptr         : consumer read byte address in the ring
//   wr_ptr         : next block write address
//   busy           : not idle
//   ring_full      : next block would overrun rd_ptr
//   blk_cnt        : blocks committed since reset (wraps)
// ---------------------------------------------------------------------------
module gtp_wr_scheduler
    import gtp_wr_scheduler_pkg::*;
#(
    parameter int          BLOCK_LEN = 16,
    parameter logic [28:0] ADDR_BASE = 29'h0000000,
    parameter logic [28:0] ADDR_SIZE = 29'h1000000
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic                   enable,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*32-1:0]      ch_dat,
    output logic [NCH-1:0]         ch_rd,
    gtp_wr_scheduler_if.master     mcb,
    input  logic [28:0]            rd_ptr,
    output logic [28:0]            wr_ptr,
    output logic                   busy,
    output logic                   ring_full,
    output logic [15:0]            blk_cnt
);

    localparam logic [28:0] BLK_BYTES = 29'(BLOCK_LEN * 4);
    localparam logic [29:0] ADDR_END  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    localparam logic [6:0]  LAST_WORD = 7'(BLOCK_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  r_last;
    logic [6:0]  r_wcnt;
    logic [28:0] r_wr_ptr;
    logic [15:0] r_blk_cnt;

    logic [1:0]  w_arb_grant;
    logic        w_arb_valid;
    logic        w_start;
    logic        w_push;
    logic        w_cmd;
    logic [29:0] w_ptr_sum;
    logic [28:0] w_ptr_nxt;

    gtp_wr_scheduler_rr_arbiter4 u_arb (
        .i_req   (ch_req),
        .i_last  (r_last),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_valid)
    );

    // Ring pointer advance with wrap back to the ring base
    assign w_ptr_sum = {1'b0, r_wr_ptr} + {1'b0, BLK_BYTES};
    assign w_ptr_nxt = (w_ptr_sum == ADDR_END) ? ADDR_BASE : w_ptr_sum[28:0];

    // An empty ring (rd == wr) is never full; otherwise full when the next
    // block would land on the consumer's read position.
    assign ring_full = (w_ptr_nxt == rd_ptr) && (rd_ptr != r_wr_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_cmd       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_arb_valid && !ring_full) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                // Pop and push come from the same term so a word is moved
                // exactly once, and a full FIFO stalls both sides together.
                if (!mcb.mcb_wr_full) begin
                    w_push = 1'b1;
                    if (r_wcnt == LAST_WORD)
                        w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!mcb.mcb_cmd_full) begin
                    w_cmd       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'd0;
            r_last    <= 2'd3;
            r_wcnt    <= 7'd0;
            r_wr_ptr  <= ADDR_BASE;
            r_blk_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_grant <= w_arb_grant;
                r_wcnt  <= 7'd0;
            end
            if (w_push)
                r_wcnt <= r_wcnt + 7'd1;
            if (w_cmd) begin
                r_wr_ptr  <= w_ptr_nxt;
                r_blk_cnt <= r_blk_cnt + 16'd1;
                r_last    <= r_grant;
            end
        end
    end

    assign ch_rd                 = w_push ? onehot4(r_grant) : '0;
    assign mcb.mcb_wr_en         = w_push;
    assign mcb.mcb_wr_data       = ch_dat[{r_grant, 5'b00000} +: 32];
    assign mcb.mcb_cmd_en        = w_cmd;
    assign mcb.mcb_cmd_instr     = MCB_INSTR_WR_AP;
    assign mcb.mcb_cmd_bl        = 6'(BLOCK_LEN - 1);
    assign mcb.mcb_cmd_byte_addr = r_wr_ptr;

    assign wr_ptr  = r_wr_ptr;
    assign busy    = (r_state != ST_IDLE);
    assign blk_cnt = r_blk_cnt;

endmodule

// File: tb/tb_gtp_wr_scheduler.sv
module tb_gtp_wr_scheduler;
    import gtp_wr_scheduler_pkg::*;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] d;
    } wexp_t;

    logic         wb_clk = 1'b0;
    logic         wb_rst = 1'b1;
    logic         enable;
    logic [3:0]   ch_req;
    logic [127:0] ch_dat;
    logic [3:0]   ch_rd;
    logic [28:0]  rd_ptr;
    logic [28:0]  wr_ptr;
    logic         busy;
    logic         ring_full;
    logic [15:0]  blk_cnt;

    // second instance with a 4-block ring
    logic         en2;
    logic [3:0]   req2;
    logic [3:0]   ch_rd2;
    logic [28:0]  rd_ptr2;
    logic [28:0]  wr_ptr2;
    logic         busy2;
    logic         ring_full2;
    logic [15:0]  blk_cnt2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wexp_t       dq[$];
    logic [28:0] cq[$];
    logic [31:0] bufcnt[4];
    logic [31:0] exp_cnt[4];
    logic [28:0] exp_addr;

    gtp_wr_scheduler_if mcb1();
    gtp_wr_scheduler_if mcb2();

    gtp_wr_scheduler #(.BLOCK_LEN(16), .ADDR_BASE(29'h0), .ADDR_SIZE(29'h1000000)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .ch_req(ch_req),
        .ch_dat(ch_dat), .ch_rd(ch_rd), .mcb(mcb1.master), .rd_ptr(rd_ptr),
        .wr_ptr(wr_ptr), .busy(busy), .ring_full(ring_full), .blk_cnt(blk_cnt)
    );

    gtp_wr_scheduler #(.BLOCK_LEN(16), .ADDR_BASE(29'h0), .ADDR_SIZE(29'h100)) dut_ring (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(en2), .ch_req(req2),
        .ch_dat(ch_dat), .ch_rd(ch_rd2), .mcb(mcb2.master), .rd_ptr(rd_ptr2),
        .wr_ptr(wr_ptr2), .busy(busy2), .ring_full(ring_full2), .blk_cnt(blk_cnt2)
    );

    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) cyc <= cyc + 1;

    // FWFT channel buffers: channel i head word = (i << 28) + words popped
    initial for (int i = 0; i < 4; i++) bufcnt[i] = 32'd0;
    always @(posedge wb_clk)
        for (int i = 0; i < 4; i++)
            if (ch_rd[i]) bufcnt[i] <= bufcnt[i] + 32'd1;
    always_comb
        for (int i = 0; i < 4; i++)
            ch_dat[32*i +: 32] = (32'(i) << 28) + bufcnt[i];

    // Scoreboard: pops expected words / commands as the DUT produces them
    always @(negedge wb_clk) begin
        logic [3:0] exp_rd;
        wexp_t      e;
        logic [28:0] a;
        exp_rd = 4'b0000;
        if (mcb1.mcb_wr_en) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL push_unexpected got=%h required=no push", mcb1.mcb_wr_data);
            end else begin
                e = dq.pop_front();
                exp_rd = 4'b0001 << e.ch;
                if (mcb1.mcb_wr_data !== e.d) begin
                    bad++;
                    $display("FAIL wr_data got=%h required=%h", mcb1.mcb_wr_data, e.d);
                end
            end
        end
        total++;
        if (ch_rd !== exp_rd) begin
            bad++;
            $display("FAIL ch_rd got=%b required=%b (cyc %0d)", ch_rd, exp_rd, cyc);
        end
        if (mcb1.mcb_cmd_en) begin
            total++;
            if (cq.size() == 0) begin
                bad++;
                $display("FAIL cmd_unexpected got addr=%h required=no cmd", mcb1.mcb_cmd_byte_addr);
            end else begin
                a = cq.pop_front();
                if ({mcb1.mcb_cmd_byte_addr, mcb1.mcb_cmd_bl, mcb1.mcb_cmd_instr} !== {a, 6'd15, 3'b010}) begin
                    bad++;
                    $display("FAIL cmd got addr=%h bl=%0d instr=%b required addr=%h bl=15 instr=010",
                             mcb1.mcb_cmd_byte_addr, mcb1.mcb_cmd_bl, mcb1.mcb_cmd_instr, a);
                end
            end
        end
    end

    task automatic push_block(input int ch);
        wexp_t e;
        for (int k = 0; k < 16; k++) begin
            e.ch = 2'(ch);
            e.d  = (32'(ch) << 28) + exp_cnt[ch] + 32'(k);
            dq.push_back(e);
        end
        exp_cnt[ch] = exp_cnt[ch] + 32'd16;
        cq.push_back(exp_addr);
        exp_addr = exp_addr + 29'h40;
    endtask

    task automatic apply_reset;
        @(negedge wb_clk);
        wb_rst = 1'b1;
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b0;
        exp_addr = 29'h0;
    endtask

    task automatic wait_cmd(input int which, output int waited);
        waited = 0;
        do begin
            @(negedge wb_clk);
            waited++;
        end while (((which == 1) ? !mcb1.mcb_cmd_en : !mcb2.mcb_cmd_en) && waited < 300);
    endtask

    task automatic test_reset;
        apply_reset();
        total++;
        if ({ch_rd, mcb1.mcb_wr_en, mcb1.mcb_cmd_en, busy, ring_full} !== 8'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b required=0", {ch_rd, mcb1.mcb_wr_en, mcb1.mcb_cmd_en, busy, ring_full});
        end
        total++;
        if (wr_ptr !== 29'h0 || blk_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_ptr got wr_ptr=%h blk_cnt=%0d required 0/0", wr_ptr, blk_cnt);
        end
    endtask

    task automatic test_single_block;
        int w;
        push_block(2);
        ch_req = 4'b0100;
        enable = 1'b1;
        wait_cmd(1, w);
        ch_req = 4'b0000;
        total++;
        if (mcb1.mcb_cmd_en !== 1'b1) begin
            bad++;
            $display("FAIL single_timeout got no cmd required cmd within 300 cycles");
        end
        @(negedge wb_clk);
        total++;
        if (wr_ptr !== 29'h40 || blk_cnt !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_post got wr_ptr=%h blk=%0d busy=%b required 40/1/0", wr_ptr, blk_cnt, busy);
        end
        total++;
        if (dq.size() != 0) begin
            bad++;
            $display("FAIL single_words got remaining=%0d required 0", dq.size());
        end
    endtask

    task automatic test_round_robin;
        int w;
        int prev;
        apply_reset();
        for (int k = 0; k < 8; k++) push_block(k % 4);
        ch_req = 4'b1111;
        prev = 0;
        for (int b = 0; b < 8; b++) begin
            wait_cmd(1, w);
            if (b == 7) ch_req = 4'b0000;
            total++;
            if (mcb1.mcb_cmd_en !== 1'b1) begin
                bad++;
                $display("FAIL rr_timeout block=%0d got no cmd required cmd", b);
            end
            if (b > 0) begin
                total++;
                if (cyc - prev != 18) begin
                    bad++;
                    $display("FAIL rr_period block=%0d got=%0d required=18", b, cyc - prev);
                end
            end
            prev = cyc;
        end
        @(negedge wb_clk);
        total++;
        if (blk_cnt !== 16'd8 || wr_ptr !== 29'h200) begin
            bad++;
            $display("FAIL rr_post got blk=%0d wr_ptr=%h required 8/200", blk_cnt, wr_ptr);
        end
    endtask

    task automatic test_wr_stall;
        int n;
        int t;
        push_block(0);
        ch_req = 4'b0001;
        n = 0; t = 0;
        while (n < 8 && t < 300) begin
            @(negedge wb_clk);
            t++;
            if (mcb1.mcb_wr_en) n++;
        end
        @(posedge wb_clk);
        #1;
        mcb1.mcb_wr_full  = 1'b1;
        mcb1.mcb_cmd_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge wb_clk);
            total++;
            if (mcb1.mcb_wr_en !== 1'b0 || ch_rd !== 4'b0) begin
                bad++;
                $display("FAIL stall_strobe cyc=%0d got wr_en=%b ch_rd=%b required 0/0", s, mcb1.mcb_wr_en, ch_rd);
            end
        end
        @(posedge wb_clk);
        #1;
        mcb1.mcb_wr_full = 1'b0;
        t = 0;
        while (n < 16 && t < 300) begin
            @(negedge wb_clk);
            t++;
            if (mcb1.mcb_wr_en) n++;
        end
        ch_req = 4'b0000;
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL stall_count got=%0d required=16", n);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge wb_clk);
            total++;
            if (mcb1.mcb_cmd_en !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL cmd_hold cyc=%0d got cmd_en=%b busy=%b required 0/1", s, mcb1.mcb_cmd_en, busy);
            end
        end
        @(posedge wb_clk);
        #1;
        mcb1.mcb_cmd_full = 1'b0;
        @(negedge wb_clk);
        total++;
        if (mcb1.mcb_cmd_en !== 1'b1) begin
            bad++;
            $display("FAIL cmd_release got=%b required=1", mcb1.mcb_cmd_en);
        end
        @(negedge wb_clk);
        total++;
        if (mcb1.mcb_cmd_en !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd9) begin
            bad++;
            $display("FAIL cmd_single got cmd_en=%b busy=%b blk=%0d required 0/0/9", mcb1.mcb_cmd_en, busy, blk_cnt);
        end
    endtask

    task automatic test_ring_full;
        int w;
        logic [28:0] exp_a[$];
        logic [28:0] a;
        apply_reset();
        enable  = 1'b0;
        ch_req  = 4'b0000;
        rd_ptr2 = 29'h0;
        en2     = 1'b1;
        req2    = 4'b0001;
        for (int b = 0; b < 3; b++) exp_a.push_back(29'(b * 'h40));
        for (int b = 0; b < 3; b++) begin
            wait_cmd(2, w);
            a = exp_a.pop_front();
            total++;
            if (mcb2.mcb_cmd_en !== 1'b1 || mcb2.mcb_cmd_byte_addr !== a) begin
                bad++;
                $display("FAIL ring_cmd block=%0d got en=%b addr=%h required 1/%h", b, mcb2.mcb_cmd_en, mcb2.mcb_cmd_byte_addr, a);
            end
        end
        for (int s = 0; s < 6; s++) begin
            @(negedge wb_clk);
            total++;
            if ({busy2, ring_full2, wr_ptr2} !== {1'b0, 1'b1, 29'hC0}) begin
                bad++;
                $display("FAIL ring_block cyc=%0d got busy=%b full=%b wr=%h required 0/1/c0", s, busy2, ring_full2, wr_ptr2);
            end
        end
        rd_ptr2 = 29'h40;
        wait_cmd(2, w);
        req2 = 4'b0000;
        total++;
        if (mcb2.mcb_cmd_en !== 1'b1 || mcb2.mcb_cmd_byte_addr !== 29'hC0) begin
            bad++;
            $display("FAIL ring_resume got en=%b addr=%h required 1/c0", mcb2.mcb_cmd_en, mcb2.mcb_cmd_byte_addr);
        end
        @(negedge wb_clk);
        total++;
        if (wr_ptr2 !== 29'h0 || ring_full2 !== 1'b1 || blk_cnt2 !== 16'd4) begin
            bad++;
            $display("FAIL ring_wrap got wr=%h full=%b blk=%0d required 0/1/4", wr_ptr2, ring_full2, blk_cnt2);
        end
        en2 = 1'b0;
    endtask

    task automatic test_enable_drop;
        int n;
        int t;
        int w;
        push_block(0);
        ch_req = 4'b0001;
        enable = 1'b1;
        n = 0; t = 0;
        while (n < 5 && t < 300) begin
            @(negedge wb_clk);
            t++;
            if (mcb1.mcb_wr_en) n++;
        end
        enable = 1'b0;
        wait_cmd(1, w);
        total++;
        if (mcb1.mcb_cmd_en !== 1'b1) begin
            bad++;
            $display("FAIL en_drop_cmd got no cmd required cmd");
        end
        for (int s = 0; s < 20; s++) begin
            @(negedge wb_clk);
            total++;
            if (busy !== 1'b0 || mcb1.mcb_wr_en !== 1'b0) begin
                bad++;
                $display("FAIL en_drop_idle cyc=%0d got busy=%b wr_en=%b required 0/0", s, busy, mcb1.mcb_wr_en);
            end
        end
        ch_req = 4'b0000;
    endtask

    task automatic test_reset_mid_block;
        int n;
        int t;
        int w;
        enable = 1'b1;
        push_block(1);
        ch_req = 4'b0010;
        n = 0; t = 0;
        while (n < 10 && t < 300) begin
            @(negedge wb_clk);
            t++;
            if (mcb1.mcb_wr_en) n++;
        end
        wb_rst = 1'b1;
        ch_req = 4'b0000;
        @(posedge wb_clk);
        #1;
        // ten words left channel 1 before the reset took effect
        dq.delete();
        cq.delete();
        exp_cnt[1] = exp_cnt[1] - 32'd6;
        exp_addr = 29'h0;
        @(negedge wb_clk);
        total++;
        if ({ch_rd, mcb1.mcb_wr_en, mcb1.mcb_cmd_en, busy} !== 7'b0) begin
            bad++;
            $display("FAIL midrst_strobes got=%b required=0", {ch_rd, mcb1.mcb_wr_en, mcb1.mcb_cmd_en, busy});
        end
        total++;
        if (wr_ptr !== 29'h0 || blk_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_ptr got wr=%h blk=%0d required 0/0", wr_ptr, blk_cnt);
        end
        wb_rst = 1'b0;
        push_block(0);
        ch_req = 4'b1111;
        wait_cmd(1, w);
        ch_req = 4'b0000;
        total++;
        if (mcb1.mcb_cmd_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_regrant got no cmd required cmd");
        end
        @(negedge wb_clk);
        total++;
        if (blk_cnt !== 16'd1 || wr_ptr !== 29'h40) begin
            bad++;
            $display("FAIL midrst_post got blk=%0d wr=%h required 1/40", blk_cnt, wr_ptr);
        end
    endtask

    task automatic test_drain;
        repeat (4) @(negedge wb_clk);
        total++;
        if (dq.size() != 0 || cq.size() != 0) begin
            bad++;
            $display("FAIL drain got words=%0d cmds=%0d required 0/0", dq.size(), cq.size());
        end
    endtask

    initial begin
        enable  = 1'b0;
        ch_req  = 4'b0000;
        rd_ptr  = 29'h0;
        en2     = 1'b0;
        req2    = 4'b0000;
        rd_ptr2 = 29'h0;
        mcb1.mcb_wr_full  = 1'b0;
        mcb1.mcb_cmd_full = 1'b0;
        mcb2.mcb_wr_full  = 1'b0;
        mcb2.mcb_cmd_full = 1'b0;
        exp_addr = 29'h0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 32'd0;

        test_reset();
        test_single_block();
        test_round_robin();
        test_wr_stall();
        test_ring_full();
        test_enable_drop();
        test_reset_mid_block();
        test_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gtp_wr_scheduler.md
Name: gtp_wr_scheduler

Overview:
- Round-robin scheduler that shares the single MCB write-only port (port 2) between the 4 GTP receiver channel buffers.
- When a channel buffer holds at least one full block, the scheduler grants it and streams BLOCK_LEN 32-bit words into the MCB write FIFO.
- It then issues one write-with-autoprecharge command at the current ring-buffer address.
- Sits between the per-channel GTP buffers and memcntr port 2; everything runs in the wb_clk domain.

Parameters:
BLOCK_LEN, 16, words per block / MCB burst (1..64); cmd_bl = BLOCK_LEN-1
ADDR_BASE, 29'h0000000, byte address of ring start (aligned to BLOCK_LEN*4)
ADDR_SIZE, 29'h1000000, ring size in bytes (multiple of BLOCK_LEN*4)

Ports:
wb_clk  in  1  clock
wb_rst  in  1  synchronous active-high reset
enable  in  1  1 = scheduling allowed; 0 = finish current block, then idle
ch_req  in  4  channel i holds >= BLOCK_LEN words (FWFT buffer)
ch_dat  in  128  channel i word at bits [32i+31:32i], valid while buffer non-empty
ch_rd  out  4  one-hot pop strobe to the granted channel buffer
mcb_wr_en  out  1  MCB port 2 write-FIFO push
mcb_wr_data  out  32  MCB write data
mcb_wr_full  in  1  MCB write FIFO full
mcb_cmd_en  out  1  MCB command strobe (1 cycle)
mcb_cmd_instr  out  3  constant 3'b010
mcb_cmd_bl  out  6  constant BLOCK_LEN-1
mcb_cmd_byte_addr  out  29  block start address
mcb_cmd_full  in  1  MCB command FIFO full
rd_ptr  in  29  consumer's read byte address within the ring
wr_ptr  out  29  next block write address
busy  out  1  state != IDLE
ring_full  out  1  next block would overrun rd_ptr
blk_cnt  out  16  blocks committed since reset (wraps)

Behaviour:
Reset values:
- state = IDLE; ch_rd = 0; mcb_wr_en = 0; mcb_cmd_en = 0; wr_ptr = ADDR_BASE; blk_cnt = 0.
- last_grant = 3, so ch0 has first priority.
- Reset mid-transfer drops the block immediately. The partial data left in the MCB FIFO is cleared by the memory reset, which is tied to the same reset.

States:
- IDLE:
  - Requires enable, ch_req != 0 and !ring_full.
  - Grant = first set bit of ch_req, searching from last_grant+1 modulo 4.
  - Latch grant and the word counter (0). Go to XFER on the next cycle.
- XFER:
  - Each cycle with !mcb_wr_full: ch_rd[grant] = 1, mcb_wr_en = 1, mcb_wr_data = granted ch_dat slice.
  - ch_rd and mcb_wr_en are combinational on state/full, so pop and push coincide exactly. Data is never duplicated or lost.
  - Word counter increments on each pushed word.
  - mcb_wr_full = 1 pauses both strobes.
  - After the BLOCK_LEN-th push, go to CMD.
- CMD:
  - When !mcb_cmd_full: mcb_cmd_en = 1 for one cycle, mcb_cmd_byte_addr = wr_ptr.
  - Same cycle: wr_ptr advances by BLOCK_LEN*4, wrapping to ADDR_BASE when it reaches ADDR_BASE+ADDR_SIZE.
  - Same cycle: blk_cnt increments, last_grant = grant, state = IDLE.
  - mcb_cmd_full = 1 holds in CMD.

Other rules:
- ring_full is combinational: next wr_ptr (with wrap) == rd_ptr while rd_ptr != wr_ptr. An empty ring (rd_ptr == wr_ptr) is not full.
- enable deasserted in XFER or CMD has no effect until IDLE. No new grant is made while enable = 0.
- ch_req falling during XFER is ignored; the request guaranteed a full block.
- Minimum block time is BLOCK_LEN+2 cycles (IDLE, XFER×N, CMD). Back-to-back blocks are allowed.
- Fairness: with all 4 requesting continuously, the grant order is 0,1,2,3,0… and no channel is skipped.
- mcb_cmd_instr and mcb_cmd_bl are constants.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE=0, ST_XFER=1, ST_CMD=2)
  - MCB_INSTR_WR_AP = 3'b010 and MCB_INSTR_RD_AP = 3'b011, shared with the port-0 controller
  - NCH = 4
- One natural sub-module: rr_arbiter4 (combinational req[3:0] + last[1:0] -> grant[1:0], valid). It is reused for read-side arbitration later.
- The ring-pointer arithmetic stays inline.

Test Plan:
1. Reset, enable=1, ch_req=4'b0100, ch2 supplies 0x2000_0000+k:
   - 16 pushes of 0x20000000..0x2000000F with ch_rd=4'b0100 on exactly those cycles.
   - Then one cmd_en with addr 0x0000000, bl=15, instr=3'b010; wr_ptr becomes 0x40; blk_cnt = 1.
2. ch_req=4'b1111 held for 8 blocks:
   - Grant sequence 0,1,2,3,0,1,2,3.
   - Addresses 0x00,0x40,…,0x1C0.
   - Each block takes 18 cycles.
3. mcb_wr_full asserted for 5 cycles after word 7:
   - No ch_rd/mcb_wr_en during the stall.
   - Word 8 resumes with correct data; exactly 16 pushes total.
   - mcb_cmd_full held 3 cycles in CMD delays cmd_en by 3 cycles, with a single pulse.
4. ADDR_SIZE=0x100, rd_ptr=0x00, 3 blocks written (wr_ptr=0xC0):
   - ring_full=1 and no grant despite ch_req.
   - Setting rd_ptr=0x40 allows block 4 at 0xC0; wr_ptr wraps to 0x00.
5. enable dropped at word 4:
   - Block completes with cmd issued, then IDLE.
   - No further grants while ch_req=4'b0001 and enable=0.
6. wb_rst asserted at word 9 of a block:
   - Next cycle: all strobes 0, state IDLE, wr_ptr=ADDR_BASE, blk_cnt=0.
   - The next grant goes to ch0 when all channels request.
